// File: rtl/led_scan_controller.sv
// Four-digit multiplexed LED scanner with double-buffered message update at frame boundaries.
// Optional anti-ghosting blanking at slot start is enabled by defining LED_SCAN_BLANK_EN.
module led_scan_controller #(
    parameter int CNT_WIDTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [23:0] msg,
    output logic [5:0]  char,
    output logic [3:0]  an,
    output logic        pending,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        D3 = 2'd0,
        D2 = 2'd1,
        D1 = 2'd2,
        D0 = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [23:0]            staging_q, staging_d;
    logic [23:0]            active_q, active_d;
    logic [5:0]             char_q, char_d;
    logic [3:0]             an_q, an_d;
    logic                   pending_q, pending_d;
    logic                   frame_tick_q, frame_tick_d;
    logic                   wrap;
    logic                   boundary;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= D3;
            cnt_q        <= '0;
            staging_q    <= '0;
            active_q     <= '0;
            char_q       <= '0;
            an_q         <= '1;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            staging_q    <= staging_d;
            active_q     <= active_d;
            char_q       <= char_d;
            an_q         <= an_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        staging_d    = staging_q;
        active_d     = active_q;
        char_d       = char_q;
        an_d         = '1;
        pending_d    = pending_q;
        frame_tick_d = 1'b0;
        wrap         = en && (cnt_q == '1);
        boundary     = wrap && (state_q == D0);

        if (en) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (wrap) begin
            case (state_q)
                D3:      state_d = D2;
                D2:      state_d = D1;
                D1:      state_d = D0;
                default: state_d = D3;
            endcase
        end

        // Staging is sampled before this edge's load, so a coincident load waits a frame.
        if (boundary) begin
            active_d     = staging_q;
            frame_tick_d = 1'b1;
        end

        if (load) begin
            staging_d = msg;
            pending_d = 1'b1;
        end else if (boundary) begin
            pending_d = 1'b0;
        end

        // Outputs are built from next-state values so they switch on the same edge as the FSM.
        if (en) begin
            case (state_d)
                D3: begin
                    char_d = active_d[23:18];
                    an_d   = 4'b0111;
                end
                D2: begin
                    char_d = active_d[17:12];
                    an_d   = 4'b1011;
                end
                D1: begin
                    char_d = active_d[11:6];
                    an_d   = 4'b1101;
                end
                default: begin
                    char_d = active_d[5:0];
                    an_d   = 4'b1110;
                end
            endcase
`ifdef LED_SCAN_BLANK_EN
            if (cnt_d[CNT_WIDTH-1:1] == '0) begin
                an_d = '1;
            end
`endif
        end
    end

    assign char       = char_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_scan_controller.sv
// Directed bench for led_scan_controller: scan order, message staging, enable hold, async reset.
module tb_led_scan_controller;

    logic        clk;
    logic        reset;
    logic        en;
    logic        load;
    logic [23:0] msg;
    logic [5:0]  char;
    logic [3:0]  an;
    logic        pending;
    logic        frame_tick;

    int checks;
    int fails;
    int e;

    led_scan_controller #(.CNT_WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (load),
        .msg        (msg),
        .char       (char),
        .an         (an),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] an_exp(int k, int c);
`ifdef LED_SCAN_BLANK_EN
        if (c < 2) return 4'b1111;
`endif
        return ~(4'b0001 << k);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            if (en) e++;
            #1;
        end
    endtask

    task automatic run_to(int target);
        while (e < target) tick(1);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        e      = 0;
        reset  = 1'b1;
        en     = 1'b0;
        load   = 1'b0;
        msg    = '0;
        #2;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_char", 32'(char), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_ftick", 32'(frame_tick), 32'h0);
        tick(3);
        reset = 1'b0;
        en    = 1'b1;
        e     = 0;

        tick(1);
        chk("d3_c1_an", 32'(an), 32'(an_exp(3, 1)));
        chk("d3_c1_char", 32'(char), 32'h0);
        run_to(15);
        chk("d3_c15_an", 32'(an), 32'h7);
        run_to(16);
        chk("d2_c0_an", 32'(an), 32'(an_exp(2, 0)));
        run_to(17);
        chk("d2_c1_an", 32'(an), 32'(an_exp(2, 1)));
        run_to(18);
        chk("d2_c2_an", 32'(an), 32'hB);
        run_to(32);
        chk("d1_c0_an", 32'(an), 32'(an_exp(1, 0)));
        run_to(48);
        chk("d0_c0_an", 32'(an), 32'(an_exp(0, 0)));
        run_to(63);
        chk("pre_bnd_ftick", 32'(frame_tick), 32'h0);
        chk("d0_c15_an", 32'(an), 32'hE);
        run_to(64);
        chk("bnd1_ftick", 32'(frame_tick), 32'h1);
        chk("bnd1_an", 32'(an), 32'(an_exp(3, 0)));
        chk("bnd1_char", 32'(char), 32'h0);
        run_to(65);
        chk("post_bnd1_ftick", 32'(frame_tick), 32'h0);

        // Back-to-back loads mid-frame; the second one must win.
        run_to(69);
        load = 1'b1;
        msg  = 24'hFFFFFF;
        tick(1);
        msg  = 24'h0C4145;
        tick(1);
        load = 1'b0;
        chk("load_pending", 32'(pending), 32'h1);
        chk("load_char_old", 32'(char), 32'h0);
        run_to(127);
        chk("pre_bnd2_pending", 32'(pending), 32'h1);
        chk("pre_bnd2_char", 32'(char), 32'h0);
        run_to(128);
        chk("bnd2_ftick", 32'(frame_tick), 32'h1);
        chk("bnd2_pending", 32'(pending), 32'h0);
        chk("bnd2_char_d3", 32'(char), 32'h3);
        run_to(129);
        chk("post_bnd2_ftick", 32'(frame_tick), 32'h0);
        run_to(144);
        chk("f2_char_d2", 32'(char), 32'h4);
        chk("f2_an_d2", 32'(an), 32'(an_exp(2, 0)));
        run_to(160);
        chk("f2_char_d1", 32'(char), 32'h5);
        run_to(176);
        chk("f2_char_d0", 32'(char), 32'h5);
        chk("f2_an_d0", 32'(an), 32'(an_exp(0, 0)));

        // Stage A, then load B exactly on the boundary edge.
        run_to(180);
        load = 1'b1;
        msg  = 24'h0420C4;
        tick(1);
        load = 1'b0;
        run_to(191);
        chk("pre_bnd3_pending", 32'(pending), 32'h1);
        chk("pre_bnd3_char", 32'(char), 32'h5);
        load = 1'b1;
        msg  = 24'h28B30D;
        tick(1);
        load = 1'b0;
        chk("bnd3_ftick", 32'(frame_tick), 32'h1);
        chk("bnd3_pending", 32'(pending), 32'h1);
        chk("bnd3_char_a3", 32'(char), 32'h1);
        run_to(208);
        chk("f3_char_a2", 32'(char), 32'h2);
        chk("f3_pending", 32'(pending), 32'h1);
        run_to(255);
        chk("f3_char_a0", 32'(char), 32'h4);
        chk("pre_bnd4_pending", 32'(pending), 32'h1);
        run_to(256);
        chk("bnd4_ftick", 32'(frame_tick), 32'h1);
        chk("bnd4_pending", 32'(pending), 32'h0);
        chk("bnd4_char_b3", 32'(char), 32'hA);

        // Pause in D1 at cnt=7.
        run_to(295);
        chk("d1_c7_an", 32'(an), 32'hD);
        chk("d1_c7_char", 32'(char), 32'hC);
        en = 1'b0;
        tick(1);
        chk("hold1_an", 32'(an), 32'hF);
        chk("hold1_char", 32'(char), 32'hC);
        tick(9);
        chk("hold10_an", 32'(an), 32'hF);
        chk("hold10_char", 32'(char), 32'hC);
        en = 1'b1;
        run_to(303);
        chk("resume_c15_an", 32'(an), 32'hD);
        run_to(304);
        chk("resume_d0_an", 32'(an), 32'(an_exp(0, 0)));
        chk("resume_d0_char", 32'(char), 32'hD);
        chk("resume_d0_ftick", 32'(frame_tick), 32'h0);

        // Asynchronous reset in the middle of a D2 slot.
        run_to(310);
        load = 1'b1;
        msg  = 24'h123456;
        tick(1);
        load = 1'b0;
        run_to(320);
        chk("bnd5_ftick", 32'(frame_tick), 32'h1);
        chk("bnd5_pending", 32'(pending), 32'h0);
        run_to(330);
        load = 1'b1;
        msg  = 24'hABCDEF;
        tick(1);
        load = 1'b0;
        run_to(340);
        chk("pre_rst_char", 32'(char), 32'h23);
        chk("pre_rst_pending", 32'(pending), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_an", 32'(an), 32'hF);
        chk("async_rst_char", 32'(char), 32'h0);
        chk("async_rst_pending", 32'(pending), 32'h0);
        chk("async_rst_ftick", 32'(frame_tick), 32'h0);
        en = 1'b0;
        tick(2);
        reset = 1'b0;
        en    = 1'b1;
        e     = 0;
        tick(1);
        chk("rst2_c1_an", 32'(an), 32'(an_exp(3, 1)));
        chk("rst2_c1_char", 32'(char), 32'h0);
        chk("rst2_pending", 32'(pending), 32'h0);
        run_to(64);
        chk("rst2_bnd_ftick", 32'(frame_tick), 32'h1);
        chk("rst2_bnd_char", 32'(char), 32'h0);
        chk("rst2_bnd_pending", 32'(pending), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/led_scan_controller.md
LED_SCAN_CONTROLLER -- requirements
Module: led_scan_controller

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 4, giving log2 of the cycles per digit slot (legal range 2..20).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit: scan enable.
REQ-005 The block SHALL have port load, input, 1 bit: a one-cycle strobe that captures msg.
REQ-006 The block SHALL have port msg, input, 24 bits: four 6-bit decoder codes; [23:18] is digit3 and [5:0] is digit0.
REQ-007 The block SHALL have port char, output, 6 bits: the code driven to the LEDdecoder char input.
REQ-008 The block SHALL have port an, output, 4 bits: active-low digit anodes; an[k] drives digit k.
REQ-009 The block SHALL have port pending, output, 1 bit: high while a staged message has not yet been applied.
REQ-010 The block SHALL have port frame_tick, output, 1 bit: a one-cycle pulse at each frame boundary.

Function
REQ-011 The FSM SHALL have states D3, D2, D1 and D0, visited in the order D3->D2->D1->D0->D3, each state being one slot of 2^CNT_WIDTH cycles.
REQ-012 Slot counter cnt (CNT_WIDTH bits) SHALL increment each cycle while en=1; the state SHALL advance in the cycle cnt wraps from all-ones to 0.
REQ-013 While en=0, cnt and the state SHALL hold, an SHALL be 4'b1111 and char SHALL hold its value.
REQ-014 The block SHALL hold a staging register and an active register, each 24 bits.
REQ-015 The staging register SHALL capture msg on load=1, and pending SHALL be set in the same edge.
REQ-016 The frame boundary SHALL be the edge on which the state goes D0->D3 with en=1.
REQ-017 At the frame boundary the active register SHALL take the staging contents held before that edge, pending SHALL clear and frame_tick SHALL be 1 for exactly the following cycle.
REQ-018 If load=1 in the same cycle as a frame boundary, the new msg SHALL go to staging, staging SHALL NOT bypass to active, and pending SHALL remain 1.
REQ-019 Back-to-back loads before a boundary SHALL overwrite staging; only the last load SHALL be applied.
REQ-020 char and an SHALL be registered, with the next-value logic evaluated from the next state and next cnt, so they change on the same edge as the state; there SHALL be no combinational path from inputs to outputs.
REQ-021 In state Dk, char SHALL equal active[6k+5:6k] and an SHALL be ~(1<<k), except as modified by REQ-025.
REQ-022 The displayed content SHALL change only at frame boundaries; no frame SHALL mix old and new digits.

Reset
REQ-023 While reset=1, asynchronously: state=D3, cnt=0, staging=0, active=0, char=6'd0, an=4'b1111, pending=0, frame_tick=0.
REQ-024 After reset falls, the first cycle with en=1 SHALL start slot D3 from cnt=0; a reset in mid-frame SHALL discard all staged and active content.

Configuration
REQ-025 When macro LED_SCAN_BLANK_EN is defined, an SHALL be 4'b1111 during cnt values 0 and 1 of every slot (anti-ghosting), with char already switched to the new digit; when it is undefined, anodes SHALL switch at cnt=0 with no blanking; frame timing SHALL be identical in both builds.

Verification
REQ-026 Reset then en=1 with no load -> an cycles 0111, 1011, 1101, 1110, 16 cycles each; char=0 throughout; frame_tick every 64 cycles.
REQ-027 A load of msg=24'h0C4145 mid-frame -> pending=1; at the next boundary, D3..D0 show codes 3, 4, 5, 5; pending=0 and frame_tick pulses once.
REQ-028 Load coincident with the boundary cycle -> the old staging is applied, the new value is applied one frame (64 cycles) later, and pending stays 1 in between.
REQ-029 en=0 for 10 cycles during D1 at cnt=7 -> an=1111 and the state holds; after resume D1 continues from cnt=7, so the slot is 16 enabled cycles long.
REQ-030 With LED_SCAN_BLANK_EN defined -> an=1111 for 2 cycles at each slot start while char already shows the new digit; without the macro there are no blank cycles.
REQ-031 Reset asserted asynchronously mid-slot D2 -> outputs go to reset values immediately without waiting for a clk edge; staging is cleared and pending=0.
